// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bus between gate_sweep_checker and the NAND/NOR/XOR gate stage,
// plus the sweep status outputs.
interface gate_sweep_checker_if #(
   parameter int unsigned ERR_W = 4
);
   logic             start;
   logic             a_out;
   logic             b_out;
   logic             nand_in;
   logic             nor_in;
   logic             exor_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [3:0]       fail_vec;

   modport slave (
      input  start, nand_in, nor_in, exor_in,
      output a_out, b_out, busy, done, pass, err_cnt, fail_vec
   );

   modport master (
      output start, nand_in, nor_in, exor_in,
      input  a_out, b_out, busy, done, pass, err_cnt, fail_vec
   );
endinterface

// File: rtl/gate_sweep_checker.sv
// Drives {a,b} through 00..11 into the gate stage, waits SETTLE cycles per vector,
// then samples NAND/NOR/XOR results and accumulates mismatches.
module gate_sweep_checker #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned ERR_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   gate_sweep_checker_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(SETTLE + 1);
   localparam int unsigned SUM_W = ERR_W + 2;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
   localparam logic [SUM_W-1:0] ERR_MAX  = SUM_W'({ERR_W{1'b1}});

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_vec;
   logic             r_a;
   logic             r_b;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err;
   logic [3:0]       r_fail;

   logic             w_exp_nand;
   logic             w_exp_nor;
   logic             w_exp_xor;
   logic [1:0]       w_mism;
   logic [SUM_W-1:0] w_sum;
   logic [ERR_W-1:0] w_err_next;
   logic [1:0]       w_vec_next;

   // Expected results are taken from the registered operands actually on the bus.
   assign w_exp_nand = ~(r_a & r_b);
   assign w_exp_nor  = ~(r_a | r_b);
   assign w_exp_xor  = r_a ^ r_b;
   assign w_mism     = {1'b0, bus.nand_in ^ w_exp_nand}
                     + {1'b0, bus.nor_in  ^ w_exp_nor}
                     + {1'b0, bus.exor_in ^ w_exp_xor};
   assign w_sum      = SUM_W'(r_err) + SUM_W'(w_mism);
   assign w_err_next = (w_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : w_sum[ERR_W-1:0];
   assign w_vec_next = r_vec + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_vec   <= '0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_fail  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_WAIT;
                  r_vec   <= '0;
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_cnt   <= CNT_LOAD;
                  r_err   <= '0;
                  r_fail  <= '0;
                  r_pass  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               r_err         <= w_err_next;
               r_fail[r_vec] <= (w_mism != 2'd0);
               if (r_vec == 2'd3) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_state <= S_WAIT;
                  r_vec   <= w_vec_next;
                  r_a     <= w_vec_next[1];
                  r_b     <= w_vec_next[0];
                  r_cnt   <= CNT_LOAD;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.a_out    = r_a;
   assign bus.b_out    = r_b;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.pass     = r_pass;
   assign bus.err_cnt  = r_err;
   assign bus.fail_vec = r_fail;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Three checker instances (SETTLE/ERR_W = 2/4, 2/3, 1/4) against a sweep-timeline
// model, with faulty, slow and noisy gate stages.
module tb_gate_sweep_checker;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gate_sweep_checker_if #(.ERR_W(4)) if0 ();
   gate_sweep_checker_if #(.ERR_W(3)) if1 ();
   gate_sweep_checker_if #(.ERR_W(4)) if2 ();

   gate_sweep_checker #(.SETTLE(2), .ERR_W(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   gate_sweep_checker #(.SETTLE(2), .ERR_W(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   gate_sweep_checker #(.SETTLE(1), .ERR_W(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   int settle [3] = '{2, 2, 1};
   int errmax [3] = '{15, 7, 15};

   // model: sweep progress as a cycle offset from the accepting edge
   bit       m_act  [3];
   int       m_k    [3];
   int       m_err  [3];
   bit [3:0] m_fail [3];
   bit       m_pass [3];

   logic       start_req, rst_req;
   int         mode;
   logic [1:0] hist [3][3];
   logic [2:0] gate [3];

   logic [1:0] d_ab   [3];
   logic       d_busy [3];
   logic       d_done [3];
   logic       d_pass [3];
   int         d_err  [3];
   logic [3:0] d_fail [3];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic snap();
      d_ab[0] = {if0.a_out, if0.b_out}; d_busy[0] = if0.busy; d_done[0] = if0.done;
      d_pass[0] = if0.pass; d_err[0] = int'(if0.err_cnt); d_fail[0] = if0.fail_vec;
      d_ab[1] = {if1.a_out, if1.b_out}; d_busy[1] = if1.busy; d_done[1] = if1.done;
      d_pass[1] = if1.pass; d_err[1] = int'(if1.err_cnt); d_fail[1] = if1.fail_vec;
      d_ab[2] = {if2.a_out, if2.b_out}; d_busy[2] = if2.busy; d_done[2] = if2.done;
      d_pass[2] = if2.pass; d_err[2] = int'(if2.err_cnt); d_fail[2] = if2.fail_vec;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_act[i] = 1'b0; m_k[i] = 0; m_err[i] = 0; m_fail[i] = '0; m_pass[i] = 1'b0;
      end
   endtask

   task automatic compare();
      int s, t, eab, ebusy, edone;
      snap();
      for (int i = 0; i < 3; i++) begin
         s = settle[i]; t = 4 * (s + 1);
         eab = 0; ebusy = 0; edone = 0;
         if (m_act[i] && m_k[i] < t) begin
            eab = m_k[i] / (s + 1); ebusy = 1;
         end else if (m_act[i]) begin
            edone = 1;
         end
         check($sformatf("dut%0d ab", i),       int'(d_ab[i]),   eab);
         check($sformatf("dut%0d busy", i),     int'(d_busy[i]), ebusy);
         check($sformatf("dut%0d done", i),     int'(d_done[i]), edone);
         check($sformatf("dut%0d pass", i),     int'(d_pass[i]), int'(m_pass[i]));
         check($sformatf("dut%0d err_cnt", i),  d_err[i],        m_err[i]);
         check($sformatf("dut%0d fail_vec", i), int'(d_fail[i]), int'(m_fail[i]));
      end
   endtask

   // Gate stage behaviour per mode: 0 good, 1 nand stuck-0, 2 xor stuck-1,
   // 3 all inverted, 4 responds to the operands of two cycles ago, 5 random noise.
   task automatic gate_apply();
      logic [1:0] fv;
      for (int i = 0; i < 3; i++) begin
         hist[i][2] = hist[i][1]; hist[i][1] = hist[i][0]; hist[i][0] = d_ab[i];
         fv = (mode == 4) ? hist[i][2] : d_ab[i];
         gate[i] = {~(fv[1] & fv[0]), ~(fv[1] | fv[0]), fv[1] ^ fv[0]};
         case (mode)
            1: gate[i][2] = 1'b0;
            2: gate[i][0] = 1'b1;
            3: gate[i] = ~gate[i];
            5: gate[i] = 3'($urandom_range(0, 7));
            default: ;
         endcase
      end
      {if0.nand_in, if0.nor_in, if0.exor_in} = gate[0];
      {if1.nand_in, if1.nor_in, if1.exor_in} = gate[1];
      {if2.nand_in, if2.nor_in, if2.exor_in} = gate[2];
   endtask

   task automatic model_step();
      int s, t, v, mism, e;
      logic [2:0] exp_g;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         s = settle[i]; t = 4 * (s + 1);
         if (m_act[i] && m_k[i] < t) begin
            if (m_k[i] % (s + 1) == s) begin
               v = m_k[i] / (s + 1);
               exp_g = {(v != 3), (v == 0), (v == 1 || v == 2)};
               mism = 0;
               for (int b = 0; b < 3; b++) if (gate[i][b] != exp_g[b]) mism++;
               e = m_err[i] + mism;
               m_err[i] = (e > errmax[i]) ? errmax[i] : e;
               m_fail[i][v] = (mism != 0);
               if (v == 3) m_pass[i] = (m_err[i] == 0);
            end
            m_k[i]++;
         end else if (m_act[i]) begin
            m_act[i] = 1'b0;
         end else if (start_req) begin
            m_act[i] = 1'b1; m_k[i] = 0; m_err[i] = 0; m_fail[i] = '0; m_pass[i] = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
      rst_n = rst_req;
      if (!rst_n) begin
         model_reset();
         #1;
         compare();
      end
      if0.start = start_req; if1.start = start_req; if2.start = start_req;
      snap();
      gate_apply();
      @(posedge clk);
      model_step();
   endtask

   task automatic run_sweep(input int m, output int lat0, output int lat2);
      mode = m; start_req = 1'b1; cycle(); start_req = 1'b0;
      lat0 = -1; lat2 = -1;
      for (int j = 0; j < 16; j++) begin
         cycle();
         if (d_done[0] && lat0 < 0) lat0 = j;
         if (d_done[2] && lat2 < 0) lat2 = j;
      end
   endtask

   initial begin
      int l0, l2, dones;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      mode = 0; start_req = 1'b0; rst_req = 1'b0;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) hist[i][j] = '0;
      if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
      {if0.nand_in, if0.nor_in, if0.exor_in} = 3'b110;
      {if1.nand_in, if1.nor_in, if1.exor_in} = 3'b110;
      {if2.nand_in, if2.nor_in, if2.exor_in} = 3'b110;
      repeat (3) cycle();
      check("reset err_cnt", d_err[0], 0);
      check("reset fail_vec", int'(d_fail[0]), 0);
      rst_req = 1'b1;
      repeat (2) cycle();

      run_sweep(0, l0, l2);
      check("latency settle2", l0, 12);
      check("latency settle1", l2, 8);
      check("good pass", int'(d_pass[0]), 1);
      check("good err", d_err[0], 0);

      run_sweep(1, l0, l2);
      check("nand0 err", d_err[0], 3);
      check("nand0 fail_vec", int'(d_fail[0]), 4'b0111);
      check("nand0 pass", int'(d_pass[0]), 0);

      run_sweep(2, l0, l2);
      check("xor1 err", d_err[0], 2);
      check("xor1 fail_vec", int'(d_fail[0]), 4'b1001);

      run_sweep(3, l0, l2);
      check("invert err w4", d_err[0], 12);
      check("invert err w3", d_err[1], 7);
      check("invert fail_vec", int'(d_fail[0]), 4'b1111);

      run_sweep(4, l0, l2);
      check("slow pass settle2", int'(d_pass[0]), 1);
      check("slow pass settle1", int'(d_pass[2]), 0);
      check("slow err settle1", d_err[2], 4);
      check("slow fail_vec settle1", int'(d_fail[2]), 4'b1010);

      mode = 0; start_req = 1'b1; dones = 0;
      for (int j = 0; j < 20; j++) begin
         cycle();
         if (d_done[0]) dones++;
      end
      check("held start done pulses", dones, 1);
      check("held start relaunch busy", int'(d_busy[0]), 1);
      start_req = 1'b0;
      repeat (16) cycle();

      mode = 0; start_req = 1'b1; cycle(); start_req = 1'b0;
      repeat (7) cycle();
      rst_req = 1'b0; cycle(); rst_req = 1'b1;
      check("midreset busy", int'(d_busy[0]), 0);
      dones = 0;
      for (int j = 0; j < 20; j++) begin
         cycle();
         if (d_done[0]) dones++;
      end
      check("midreset no done", dones, 0);
      run_sweep(0, l0, l2);
      check("after reset pass", int'(d_pass[0]), 1);
      check("after reset latency", l0, 12);

      for (int n = 0; n < 400; n++) begin
         if (n % 30 == 0) mode = $urandom_range(0, 5);
         rst_req   = ($urandom_range(0, 39) != 0);
         start_req = ($urandom_range(0, 3) == 0);
         cycle();
      end
      rst_req = 1'b1; start_req = 1'b0;
      repeat (20) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
